conv_window_reader: RTL
=======================

CONV_WINDOW_READER -- requirements
Module: conv_window_reader

Interface
REQ-001 Parameter MAP_W, default 32: feature-map width in bytes; MAP_W*MAP_H SHALL be at most 1024.
REQ-002 Parameter MAP_H, default 32: feature-map height in rows.
REQ-003 Port clk, input, 1: clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: one-cycle pulse meaning the ping-pong buffer bank now holds a complete map.
REQ-006 Port rd_addr_25P, output, 800: 25 lanes x 32-bit read addresses to the ping-pong buffer; lane j occupies bits [32j+31:32j].
REQ-007 Port rd_dout, input, 200: 25 lanes x 8-bit buffer read data; lane j occupies bits [8j+7:8j]; valid 1 cycle after its address.
REQ-008 Port win_data, output, 200: captured 5x5 window; lane j = ky*5+kx.
REQ-009 Port win_valid, output, 1: win_data, win_row and win_col are valid.
REQ-010 Port win_ready, input, 1: downstream accepts the window.
REQ-011 Port win_row / win_col, output, 8 each: top-left coordinate of the current window.
REQ-012 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-013 Port done, output, 1: one-cycle pulse after the last window handshake.

Function
REQ-014 FSM states SHALL be IDLE, ADDR, LAT, VALID and DONE.
REQ-015 IDLE: on start=1, row=0 and col=0 are loaded and the FSM moves to ADDR; start in any other state SHALL be ignored.
REQ-016 ADDR: rd_addr_25P is registered with lane j = (row+ky)*MAP_W + (col+kx); bits [31:11] of each lane are 0. The FSM moves to LAT.
REQ-017 LAT: buffer read latency cycle; rd_dout is captured into win_data at the end of LAT, and the FSM moves to VALID.
REQ-018 VALID: win_valid=1; win_data, win_row, win_col and rd_addr_25P are held stable until win_valid & win_ready.
REQ-019 On handshake: if col < MAP_W-5, col increments; otherwise col resets to 0 and row increments; the FSM then goes to ADDR.
REQ-020 Handshake at row=MAP_H-5, col=MAP_W-5 SHALL move the FSM to DONE; in DONE, done=1 for one cycle, then the FSM returns to IDLE.
REQ-021 Stride is 1 and there is no padding; a map produces (MAP_H-4)*(MAP_W-4) windows in raster order.
REQ-022 Throughput SHALL be 1 window per 3 cycles when win_ready is held high.
REQ-023 Address arithmetic SHALL be unsigned and at least 11 bits wide, with no wrap-around for legal parameters.
REQ-024 win_ready while win_valid=0 SHALL have no effect.
REQ-025 A start pulse in the same cycle as done SHALL be ignored.
REQ-026 busy=1 in ADDR, LAT and VALID, and 0 in IDLE and DONE.

Reset
REQ-027 Asserting rst_n=0 at any time, including mid-map, SHALL force IDLE with row=0, col=0, rd_addr_25P=0, win_data=0, win_valid=0, busy=0 and done=0.
REQ-028 After rst_n deasserts, the block SHALL wait for a new start pulse; no partial map resumes.

Structure
REQ-029 Shared package cnn_pkg SHALL hold K=5, LANES=25, ADDR_LANE_W=32, DATA_W=8 and the FSM state encoding.
REQ-030 One sub-module, window_addr_gen, SHALL combinationally compute the 25 lane addresses from row, col and MAP_W; the top level registers its output.

Verification
REQ-031 Reset mid-map: assert rst_n=0 while in VALID at row=3, col=7 -> all outputs 0 and state IDLE immediately; after release, the next start begins at row=0, col=0.
REQ-032 Single window: MAP_W=MAP_H=32, start -> ADDR cycle lane0=0, lane4=4, lane5=32, lane24=132; win_valid 2 cycles later with win_row=0 and win_col=0.
REQ-033 Row wrap: handshake at col=27 -> next window win_row=1, win_col=0, lane0=32.
REQ-034 Full map: buffer preloaded with byte value = addr[7:0], win_ready=1 -> exactly 784 windows, each lane matching its address; done pulse 1 cycle after the last handshake; 2352 cycles from first ADDR to done.
REQ-035 Backpressure: win_ready=0 for 10 cycles in VALID -> win_valid, win_data and rd_addr_25P unchanged; advance occurs on the first cycle win_ready=1.
REQ-036 Ignored start: start pulses while busy=1 and coincident with done -> window count and sequence unchanged; busy stays 0 after done.

Source files
------------

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg : shared window geometry, lane widths and reader FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cnn_pkg;
    localparam int K           = 5;
    localparam int LANES       = K * K;
    localparam int ADDR_LANE_W = 32;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 11;
    localparam int COORD_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LAT   = 3'd2,
        ST_VALID = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
endpackage

`default_nettype wire

// File: rtl/window_addr_gen.sv
// ---------------------------------------------------------------------------
// window_addr_gen : combinational 5x5 lane addresses for a window at row/col
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module window_addr_gen
    import cnn_pkg::*;
#(
    parameter int MAP_W = 32
) (
    input  logic [COORD_W-1:0]           i_row,
    input  logic [COORD_W-1:0]           i_col,
    output logic [LANES*ADDR_LANE_W-1:0] o_addr
);

    // Upper lane bits stay zero; legal maps never exceed ADDR_W bits.
    always_comb begin
        o_addr = '0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                o_addr[ADDR_LANE_W*(ky*K+kx) +: ADDR_W] =
                    ADDR_W'((int'(i_row) + ky) * MAP_W + int'(i_col) + kx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_window_reader.sv
// ---------------------------------------------------------------------------
// conv_window_reader : raster-scans 5x5 stride-1 windows out of a feature map
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv_window_reader
    import cnn_pkg::*;
#(
    parameter int MAP_W = 32,
    parameter int MAP_H = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [LANES*ADDR_LANE_W-1:0]  rd_addr_25P,
    input  logic [LANES*DATA_W-1:0]       rd_dout,
    output logic [LANES*DATA_W-1:0]       win_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [COORD_W-1:0]            win_row,
    output logic [COORD_W-1:0]            win_col,
    output logic                          busy,
    output logic                          done
);

    localparam logic [COORD_W-1:0] C_LAST_COL = COORD_W'(MAP_W - K);
    localparam logic [COORD_W-1:0] C_LAST_ROW = COORD_W'(MAP_H - K);

    state_t                          r_state;
    logic [COORD_W-1:0]              r_row;
    logic [COORD_W-1:0]              r_col;
    logic [LANES*ADDR_LANE_W-1:0]    r_addr;
    logic [LANES*DATA_W-1:0]         r_win;
    logic                            r_valid;
    logic                            r_busy;
    logic                            r_done;

    logic [COORD_W-1:0]              w_nrow;
    logic [COORD_W-1:0]              w_ncol;
    logic [LANES*ADDR_LANE_W-1:0]    w_addr;
    logic                            w_last;

    // Next window coordinate; addresses are generated for it so that they
    // are already on the bus during the ADDR cycle.
    always_comb begin
        w_nrow = r_row;
        w_ncol = r_col;
        if (r_state == ST_IDLE) begin
            w_nrow = '0;
            w_ncol = '0;
        end else if (r_col < C_LAST_COL) begin
            w_ncol = r_col + 1'b1;
        end else begin
            w_ncol = '0;
            w_nrow = r_row + 1'b1;
        end
    end

    assign w_last = (r_row == C_LAST_ROW) && (r_col == C_LAST_COL);

    window_addr_gen #(
        .MAP_W (MAP_W)
    ) u_addr_gen (
        .i_row  (w_nrow),
        .i_col  (w_ncol),
        .o_addr (w_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_row   <= w_nrow;
                        r_col   <= w_ncol;
                        r_addr  <= w_addr;
                        r_busy  <= 1'b1;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_LAT;
                end
                ST_LAT: begin
                    r_win   <= rd_dout;
                    r_valid <= 1'b1;
                    r_state <= ST_VALID;
                end
                ST_VALID: begin
                    if (win_ready) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_row   <= w_nrow;
                            r_col   <= w_ncol;
                            r_addr  <= w_addr;
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr_25P = r_addr;
    assign win_data    = r_win;
    assign win_valid   = r_valid;
    assign win_row     = r_row;
    assign win_col     = r_col;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

`default_nettype wire
